// File: rtl/shift_pkg.sv
// Shared definitions for the shift-loop controller.
//   state_t        : controller state encoding (IDLE, SHIFT, DRAIN, DONE)
//   ERR_W_DEFAULT  : default width of the saturating mismatch counter
//   calc_cnt_w()   : cycle-counter width, clog2(WIDTH+DEPTH+1), so the
//                    counter can hold the last busy cycle index WIDTH+DEPTH
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ERR_W_DEFAULT = 8;

    function automatic int calc_cnt_w(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction

endpackage

// File: rtl/shift_loop_ctrl.sv
// Loopback / BIST sequencer for a DEPTH-stage serial shift register.
// A word accepted on the in_* handshake is driven LSB-first on ser_out; the
// shift register output (ser_in) is realigned by DEPTH cycles and recaptured.
// The recaptured word is presented on out_* together with a match flag and a
// saturating count of mismatching words.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   in_valid/in_ready/in_data    word to send (in_ready decoded from state)
//   ser_out / ser_in             to shift register sin / from its sout
//   out_valid/out_ready/out_data recaptured word (held until consumed)
//   match                        out_data equals the sent word
//   busy                         controller not idle (decoded from state)
//   err_cnt                      saturating count of mismatching words
module shift_loop_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int ERR_W = ERR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    input  logic             ser_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             match,
    output logic             busy,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int CNT_W = calc_cnt_w(WIDTH, DEPTH);

    // Cycle k (k-th cycle after the accept edge) is tracked as cnt_q == k.
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CAP_FIRST  = CNT_W'(DEPTH + 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(DEPTH + WIDTH);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   tx_q;
    logic [WIDTH-1:0]   rx_q;
    logic               ser_out_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               match_q;
    logic [ERR_W-1:0]   err_cnt_q;

    logic [WIDTH-1:0]   rx_d;
    logic               tx_bit_d;
    logic               cap_en;
    logic [CNT_W-1:0]   cap_idx;

    // rx_d is the capture register including this cycle's ser_in bit, so the
    // final bit is already part of the word loaded into out_data at the end
    // of cycle WIDTH+DEPTH. tx_bit_d is the bit to drive in the next cycle.
    always_comb begin
        cap_en   = ((state_q == SHIFT) || (state_q == DRAIN)) &&
                   (cnt_q >= CAP_FIRST) && (cnt_q <= CAP_LAST);
        cap_idx  = cnt_q - CAP_FIRST;
        rx_d     = rx_q;
        tx_bit_d = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            if (cap_en && (cap_idx == CNT_W'(b))) begin
                rx_d[b] = ser_in;
            end
            if (cnt_q == CNT_W'(b)) begin
                tx_bit_d = tx_q[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            ser_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            match_q     <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ser_out_q <= 1'b0;
                    if (in_valid) begin
                        tx_q      <= in_data;
                        rx_q      <= '0;
                        ser_out_q <= in_data[0];
                        cnt_q     <= CNT_ONE;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT, DRAIN: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    rx_q  <= rx_d;
                    // Capture may overlap SHIFT when DEPTH < WIDTH, so the
                    // end-of-word check comes first and applies in both states.
                    if (cnt_q == CAP_LAST) begin
                        state_q     <= DONE;
                        cnt_q       <= '0;
                        ser_out_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= rx_d;
                        match_q     <= (rx_d == tx_q);
                        if ((rx_d != tx_q) && (err_cnt_q != '1)) begin
                            err_cnt_q <= err_cnt_q + ERR_W'(1);
                        end
                    end else if (cnt_q == SHIFT_LAST) begin
                        state_q   <= DRAIN;
                        ser_out_q <= 1'b0;
                    end else if (state_q == SHIFT) begin
                        ser_out_q <= tx_bit_d;
                    end
                end
                DONE: begin
                    // out_data is intentionally held after the handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign ser_out   = ser_out_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign match     = match_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_shift_loop_ctrl.sv
module tb_shift_loop_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    int errors = 0;
    int checks = 0;

    // ---------------- instance A: WIDTH=8, DEPTH=4, ERR_W=8 ----------------
    logic       in_valid_a = 1'b0, out_ready_a = 1'b1;
    logic [7:0] in_data_a = 8'h00;
    logic       in_ready_a, ser_out_a, ser_in_a, out_valid_a, match_a, busy_a;
    logic [7:0] out_data_a, err_cnt_a;
    int         fault_a = 0;       // 0 ideal, 1 stuck-at-0, 2 stuck-at-1
    int         err_model_a = 0;
    logic       sr_a [4];

    always @(posedge clk) begin
        for (int i = 3; i > 0; i--) sr_a[i] <= sr_a[i-1];
        sr_a[0] <= ser_out_a;
    end
    assign ser_in_a = (fault_a == 1) ? 1'b0 : (fault_a == 2) ? 1'b1 : sr_a[3];

    shift_loop_ctrl #(.WIDTH(8), .DEPTH(4), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .ser_out(ser_out_a), .ser_in(ser_in_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .match(match_a), .busy(busy_a), .err_cnt(err_cnt_a)
    );

    // ---------------- instance B: ERR_W=2, stuck-at-1 ----------------
    logic       in_valid_b = 1'b0, out_ready_b = 1'b1;
    logic [7:0] in_data_b = 8'h00;
    logic       in_ready_b, ser_out_b, out_valid_b, match_b, busy_b;
    logic [7:0] out_data_b;
    logic [1:0] err_cnt_b;
    logic       ser_in_b;
    assign ser_in_b = 1'b1;

    shift_loop_ctrl #(.WIDTH(8), .DEPTH(4), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .ser_out(ser_out_b), .ser_in(ser_in_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .match(match_b), .busy(busy_b), .err_cnt(err_cnt_b)
    );

    // ---------------- instance C: WIDTH=1, DEPTH=1, ideal ----------------
    logic       in_valid_c = 1'b0, out_ready_c = 1'b1;
    logic [0:0] in_data_c = 1'b0;
    logic       in_ready_c, ser_out_c, out_valid_c, match_c, busy_c;
    logic [0:0] out_data_c;
    logic [7:0] err_cnt_c;
    logic       sr_c;
    always @(posedge clk) sr_c <= ser_out_c;

    shift_loop_ctrl #(.WIDTH(1), .DEPTH(1), .ERR_W(8)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c),
        .ser_out(ser_out_c), .ser_in(sr_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c),
        .match(match_c), .busy(busy_c), .err_cnt(err_cnt_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // What the loop returns for a word given the fault on the return path.
    function automatic logic [7:0] model_rx(input logic [7:0] w, input int fault);
        if (fault == 1) return 8'h00;
        if (fault == 2) return 8'hFF;
        return w;
    endfunction

    // Send one word through instance A and check the whole transaction.
    task automatic run_word_a(input logic [7:0] w, input int hold);
        int cyc;
        logic [7:0] exp_d;
        logic exp_m;
        logic eb;
        cyc = 0;
        while (in_ready_a !== 1'b1 && cyc < 50) begin
            step();
            cyc++;
        end
        checks++;
        if (in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait_a got=%b want=1", in_ready_a);
        end
        out_ready_a = (hold == 0);
        in_valid_a = 1'b1;
        in_data_a  = w;
        step();                                   // accept edge -> cycle 1
        exp_d = model_rx(w, fault_a);
        exp_m = (exp_d == w);
        for (int k = 1; k <= 12; k++) begin
            eb = (k <= 8) ? w[k-1] : 1'b0;
            checks++;
            if (ser_out_a !== eb) begin
                errors++;
                $display("FAIL ser_out_a cycle=%0d got=%b want=%b", k, ser_out_a, eb);
            end
            checks++;
            if (out_valid_a !== 1'b0) begin
                errors++;
                $display("FAIL early_valid_a cycle=%0d got=%b want=0", k, out_valid_a);
            end
            in_valid_a = 1'($urandom_range(0, 1));  // must be ignored while busy
            in_data_a  = 8'($urandom);
            step();
        end
        in_valid_a = 1'b0;
        if (!exp_m && err_model_a < 255) err_model_a++;
        checks++;
        if (out_valid_a !== 1'b1) begin
            errors++;
            $display("FAIL latency_a got=%b want=1 in cycle 13", out_valid_a);
        end
        checks++;
        if (out_data_a !== exp_d) begin
            errors++;
            $display("FAIL out_data_a got=%h want=%h", out_data_a, exp_d);
        end
        checks++;
        if (match_a !== exp_m) begin
            errors++;
            $display("FAIL match_a got=%b want=%b", match_a, exp_m);
        end
        checks++;
        if (err_cnt_a !== 8'(err_model_a)) begin
            errors++;
            $display("FAIL err_cnt_a got=%0d want=%0d", err_cnt_a, err_model_a);
        end
        for (int h = 0; h < hold; h++) begin
            in_valid_a = 1'($urandom_range(0, 1));
            in_data_a  = 8'($urandom);
            step();
            checks++;
            if (out_valid_a !== 1'b1 || out_data_a !== exp_d || match_a !== exp_m || in_ready_a !== 1'b0) begin
                errors++;
                $display("FAIL hold_a cyc=%0d got v=%b d=%h m=%b r=%b want v=1 d=%h m=%b r=0",
                         h, out_valid_a, out_data_a, match_a, in_ready_a, exp_d, exp_m);
            end
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        step();                                   // handshake edge
        checks++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_data_a !== exp_d) begin
            errors++;
            $display("FAIL release_a got v=%b r=%b d=%h want v=0 r=1 d=%h",
                     out_valid_a, in_ready_a, out_data_a, exp_d);
        end
        $display("txn A: word=%h fault=%0d hold=%0d out=%h match=%b err_cnt=%0d",
                 w, fault_a, hold, out_data_a, match_a, err_cnt_a);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (6) step();
        checks++;
        if (busy_a !== 1'b0 || ser_out_a !== 1'b0 || out_valid_a !== 1'b0 ||
            out_data_a !== 8'h00 || match_a !== 1'b0 || err_cnt_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_state_a got busy=%b so=%b v=%b d=%h m=%b e=%0d want all 0",
                     busy_a, ser_out_a, out_valid_a, out_data_a, match_a, err_cnt_a);
        end
        rst = 1'b1;
        step();
        checks++;
        if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1 || in_ready_c !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got a=%b b=%b c=%b want 1", in_ready_a, in_ready_b, in_ready_c);
        end
        $display("txn reset: busy=%b in_ready=%b err_cnt=%0d", busy_a, in_ready_a, err_cnt_a);
    endtask

    task automatic test_loopback();
        fault_a = 0;
        run_word_a(8'hA5, 0);
    endtask

    task automatic test_stuck0();
        fault_a = 1;
        run_word_a(8'hFF, 0);
        run_word_a(8'h00, 0);
        fault_a = 0;
    endtask

    task automatic test_back_to_back();
        fault_a = 0;
        run_word_a(8'h3C, 5);
        run_word_a(8'hC3, 0);
    endtask

    task automatic test_reset_mid();
        fault_a = 0;
        in_valid_a = 1'b1;
        in_data_a  = 8'h5A;
        step();                                   // cycle 1
        in_valid_a = 1'b0;
        repeat (5) step();                        // cycle 6
        rst = 1'b0;
        step();
        err_model_a = 0;
        checks++;
        if (busy_a !== 1'b0 || ser_out_a !== 1'b0 || out_valid_a !== 1'b0 || err_cnt_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_a got busy=%b so=%b v=%b e=%0d want 0 0 0 0",
                     busy_a, ser_out_a, out_valid_a, err_cnt_a);
        end
        $display("txn reset_mid: busy=%b err_cnt=%0d", busy_a, err_cnt_a);
        rst = 1'b1;
        step();
        run_word_a(8'h81, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            fault_a = $urandom_range(0, 2);
            run_word_a(8'($urandom), $urandom_range(0, 3));
        end
        fault_a = 0;
    endtask

    task automatic test_saturation();
        int cyc;
        int exp_e = 0;
        for (int n = 0; n < 4; n++) begin
            in_valid_b = 1'b1;
            in_data_b  = 8'h00;
            step();
            in_valid_b = 1'b0;
            cyc = 0;
            while (out_valid_b !== 1'b1 && cyc < 40) begin
                step();
                cyc++;
            end
            if (exp_e < 3) exp_e++;
            checks++;
            if (out_valid_b !== 1'b1) begin
                errors++;
                $display("FAIL sat_timeout_b word=%0d got=%b want=1", n, out_valid_b);
            end
            checks++;
            if (out_data_b !== 8'hFF || match_b !== 1'b0 || err_cnt_b !== 2'(exp_e)) begin
                errors++;
                $display("FAIL sat_b word=%0d got d=%h m=%b e=%0d want d=ff m=0 e=%0d",
                         n, out_data_b, match_b, err_cnt_b, exp_e);
            end
            $display("txn B: word=00 out=%h match=%b err_cnt=%0d", out_data_b, match_b, err_cnt_b);
            step();                               // handshake (out_ready_b=1)
        end
    endtask

    task automatic test_edge_params();
        logic [0:0] w;
        for (int n = 0; n < 4; n++) begin
            w = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid_c = 1'b1;
            in_data_c  = w;
            step();                               // cycle 1
            in_valid_c = 1'b0;
            in_data_c  = ~w;
            checks++;
            if (ser_out_c !== w[0] || out_valid_c !== 1'b0) begin
                errors++;
                $display("FAIL edge_c1 got so=%b v=%b want so=%b v=0", ser_out_c, out_valid_c, w[0]);
            end
            step();                               // cycle 2
            checks++;
            if (ser_out_c !== 1'b0 || out_valid_c !== 1'b0) begin
                errors++;
                $display("FAIL edge_c2 got so=%b v=%b want so=0 v=0", ser_out_c, out_valid_c);
            end
            step();                               // cycle 3
            checks++;
            if (out_valid_c !== 1'b1 || out_data_c !== w || match_c !== 1'b1 || err_cnt_c !== 8'h00) begin
                errors++;
                $display("FAIL edge_c3 got v=%b d=%b m=%b e=%0d want v=1 d=%b m=1 e=0",
                         out_valid_c, out_data_c, match_c, err_cnt_c, w);
            end
            $display("txn C: word=%b out=%b match=%b", w, out_data_c, match_c);
            step();                               // handshake
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loopback();
        test_stuck0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturation();
        test_edge_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
